vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Owns the single-port pixel frame-buffer RAM that feeds the VGA timing generator.
- The display read (driven by vgac's rdn/row_addr/col_addr) has absolute priority.
- Two game-side writers (map renderer, sprite/tank engine) share the remaining cycles round-robin, one write per cycle.
- Returns the read pixel as d_out with a fixed latency. The frame buffer is 160x120 at 12 bit and is up-scaled x4 onto the 640x480 display.

Parameters:
- FB_W, 160, frame-buffer width in pixels.
- FB_H, 120, frame-buffer height in pixels.
- SCALE_SH, 2, log2 of the display-to-frame-buffer scale factor.
- ADDR_W, 15, RAM address width; must satisfy 2^ADDR_W >= FB_W*FB_H.
- PIX_W, 12, pixel width in bbbb_gggg_rrrr format.

Ports:
- vga_clk  in  1  pixel clock; the only clock.
- clrn  in  1  reset, synchronous, active-low.
- rdn  in  1  display read request from vgac, active-low.
- row_addr  in  10  display row, 0..479.
- col_addr  in  10  display column, 0..639.
- d_out  out  PIX_W  pixel to vgac d_in.
- d_valid  out  1  d_out holds a display pixel.
- wr_req  in  2  per-writer write request; must be held until acked.
- wr_addr0, wr_addr1  in  ADDR_W  frame-buffer write address.
- wr_data0, wr_data1  in  PIX_W  write pixel.
- wr_ack  out  2  one-cycle pulse per writer when its write is issued or dropped.
- wr_err  out  1  one-cycle pulse when an out-of-range write is dropped.
- ram_addr  out  ADDR_W  RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  PIX_W  RAM write data.
- ram_rdata  in  PIX_W  RAM synchronous read data, valid 1 cycle after ram_addr.

Behaviour:
- Reset: when clrn=0 at a vga_clk edge, all registered outputs go to 0: ram_addr, ram_we, ram_wdata, wr_ack, wr_err, d_out, d_valid. The round-robin pointer resets to writer 0. Reset mid-write means the write is not issued and not acked; the writer must re-request.
- Decision/issue pipeline: each cycle t the arbiter makes one decision from the inputs sampled at t. ram_* and wr_ack/wr_err are registered and appear at t+1.
- Priority, evaluated at cycle t:
  - If rdn=0: DISP.
    - ram_addr <= (row_addr>>SCALE_SH)*FB_W + (col_addr>>SCALE_SH).
    - ram_we <= 0.
    - No writer is acked.
  - Else, if any eligible wr_req: grant WRITE.
    - When both writers are eligible, grant the one the pointer names; the pointer then moves to the other writer.
    - When only one is eligible, grant it; the pointer moves to the other writer.
  - Else IDLE: ram_we <= 0 and ram_addr holds its value.
- Eligibility: wr_req[i] is ineligible in the cycle where wr_ack[i] is high. This prevents a double grant while the writer drops req.
- WRITE with wr_addr < FB_W*FB_H: ram_we <= 1, ram_addr/ram_wdata <= the writer's addr/data, wr_ack[i] <= 1.
- WRITE with wr_addr >= FB_W*FB_H (19200..32767): ram_we <= 0, wr_ack[i] <= 1, wr_err <= 1. The RAM is untouched.
- Display addressing arithmetic: width ADDR_W, unsigned. Row/col shifts truncate. No clamping; vgac guarantees in-range row/col while rdn=0.
- Read return path:
  - Track the DISP decision through a 2-stage valid pipe.
  - The cycle after ram_addr is presented, register d_out <= ram_rdata and d_valid <= 1.
  - Otherwise d_out <= 0 and d_valid <= 0.
  - Latency from rdn=0 sample to d_valid=1 is 3 cycles, fixed.
- Starvation: writers are served only during blanking. With a 640-cycle active line, a held request waits at most 640+1 cycles plus one competing grant.
- rdn toggling every cycle is legal; each rdn=0 cycle produces exactly one DISP access.

Decomposition:
- Shared package vga_pkg holds:
  - Constants: FB_W, FB_H, SCALE_SH, FB_DEPTH=FB_W*FB_H, the pixel type (logic [11:0]), and the address type.
  - Enum arb_sel_t {SEL_IDLE, SEL_DISP, SEL_W0, SEL_W1}.
- One sub-module, vram_rr_pick: the 2-way round-robin picker with masking. Inputs are req, ack mask and pointer; outputs are the one-hot grant and the next pointer. It is purely combinational; the pointer register stays in vram_arbiter.

Test Plan:
- Reset hold: clrn=0 for 3 cycles with wr_req=2'b11 and rdn=0 -> every output stays 0; no ram_we; pointer at writer 0 after release.
- Display priority: rdn=0, row=5, col=13, wr_req=2'b01 -> ram_addr=1*160+3=163 at t+1; no ack. rdn=1 next -> wr_ack[0] exactly one cycle later.
- Round robin: rdn=1, both requesters held with each dropping req 1 cycle after its ack; addr0=10, addr1=20 -> RAM writes in order W0, W1, W0, W1; ack pulses alternate; never two acks in one cycle.
- Out-of-range write: wr_req[1]=1, wr_addr1=19200 -> wr_ack[1]=1 and wr_err=1 for one cycle; ram_we=0 throughout.
- Read latency: RAM model returns 12'hABC for address 0; rdn=0 with row=col=0 at t -> d_valid=1 and d_out=12'hABC at t+3. With rdn=1 -> d_valid=0 and d_out=0.
- Reset mid-operation: assert clrn=0 on the cycle a write is decided -> no ram_we and no ack at the next cycle. Re-request after release -> write issued normally.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants, types and helpers for the frame-buffer arbiter.
package vga_pkg;

  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int SCALE_SH = 2;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int ADDR_W   = 15;
  localparam int PIX_W    = 12;

  typedef logic [PIX_W-1:0]  pix_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    SEL_IDLE,
    SEL_DISP,
    SEL_W0,
    SEL_W1
  } arb_sel_t;

  // Map a 640x480 display coordinate onto the down-scaled frame buffer.
  function automatic addr_t disp_addr(input logic [9:0] row, input logic [9:0] col);
    addr_t r;
    addr_t c;
    r = addr_t'(row >> SCALE_SH);
    c = addr_t'(col >> SCALE_SH);
    return addr_t'(r * addr_t'(FB_W) + c);
  endfunction

endpackage

// File: rtl/vram_rr_pick.sv
// Two-way round-robin picker. A request whose ack is currently high is
// masked so a writer that is still dropping its request is not granted twice.
module vram_rr_pick (
  input  logic [1:0] req,
  input  logic [1:0] ack_mask,
  input  logic       ptr,
  output logic [1:0] gnt,
  output logic       ptr_next
);

  logic [1:0] elig;

  assign elig = req & ~ack_mask;

  // Choose one eligible writer; the pointer always moves past the winner.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    gnt      = 2'b00;
    ptr_next = ptr;
    unique case (elig)
      2'b01: begin
        gnt      = 2'b01;
        ptr_next = 1'b1;
      end
      2'b10: begin
        gnt      = 2'b10;
        ptr_next = 1'b0;
      end
      2'b11: begin
        gnt      = ptr ? 2'b10 : 2'b01;
        ptr_next = ~ptr;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vram_arbiter.sv
// Frame-buffer RAM arbiter: display reads win outright, two game-side
// writers share the leftover cycles round-robin, and read data comes back
// on d_out three cycles after the rdn=0 sample.
module vram_arbiter
  import vga_pkg::*;
(
  input  logic              vga_clk,
  input  logic              clrn,
  input  logic              rdn,
  input  logic [9:0]        row_addr,
  input  logic [9:0]        col_addr,
  output logic [PIX_W-1:0]  d_out,
  output logic              d_valid,
  input  logic [1:0]        wr_req,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [PIX_W-1:0]  wr_data0,
  input  logic [PIX_W-1:0]  wr_data1,
  output logic [1:0]        wr_ack,
  output logic              wr_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [PIX_W-1:0]  ram_wdata,
  input  logic [PIX_W-1:0]  ram_rdata
);

  addr_t      ram_addr_q,  ram_addr_d;
  logic       ram_we_q,    ram_we_d;
  pix_t       ram_wdata_q, ram_wdata_d;
  logic [1:0] wr_ack_q,    wr_ack_d;
  logic       wr_err_q,    wr_err_d;
  logic       ptr_q,       ptr_d;
  logic       disp_v1_q,   disp_v1_d;
  logic       disp_v2_q,   disp_v2_d;
  logic       d_valid_q,   d_valid_d;
  pix_t       d_out_q,     d_out_d;

  logic [1:0] gnt;
  logic       ptr_next;
  arb_sel_t   sel;
  addr_t      w_addr;
  pix_t       w_data;

  vram_rr_pick u_pick (
    .req      (wr_req),
    .ack_mask (wr_ack_q),
    .ptr      (ptr_q),
    .gnt      (gnt),
    .ptr_next (ptr_next)
  );

  // One decision per cycle: display first, then the picked writer, else idle.
  always_comb begin
    if (!rdn)        sel = SEL_DISP;
    else if (gnt[0]) sel = SEL_W0;
    else if (gnt[1]) sel = SEL_W1;
    else             sel = SEL_IDLE;

    w_addr = (sel == SEL_W1) ? wr_addr1 : wr_addr0;
    w_data = (sel == SEL_W1) ? wr_data1 : wr_data0;

    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    wr_ack_d    = 2'b00;
    wr_err_d    = 1'b0;
    ptr_d       = ptr_q;

    unique case (sel)
      SEL_DISP: ram_addr_d = disp_addr(row_addr, col_addr);
      SEL_W0, SEL_W1: begin
        ptr_d = ptr_next;
        wr_ack_d[(sel == SEL_W1) ? 1 : 0] = 1'b1;
        if (w_addr < addr_t'(FB_DEPTH)) begin
          ram_we_d    = 1'b1;
          ram_addr_d  = w_addr;
          ram_wdata_d = w_data;
        end else begin
          // Off the end of the frame buffer: retire the request, flag it, leave RAM alone.
          wr_err_d = 1'b1;
        end
      end
      default: ;
    endcase

    // Read return: stage 1 is the address cycle, stage 2 the RAM data cycle.
    disp_v1_d = (sel == SEL_DISP);
    disp_v2_d = disp_v1_q;
    d_valid_d = disp_v2_q;
    d_out_d   = disp_v2_q ? ram_rdata : '0;
  end

  // State and registered outputs.
  always_ff @(posedge vga_clk) begin
    // NOTE: clrn is sampled on the clock edge (synchronous reset), so it belongs inside the clocked branch only.
    if (!clrn) begin
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_wdata_q <= '0;
      wr_ack_q    <= 2'b00;
      wr_err_q    <= 1'b0;
      ptr_q       <= 1'b0;
      disp_v1_q   <= 1'b0;
      disp_v2_q   <= 1'b0;
      d_valid_q   <= 1'b0;
      d_out_q     <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values, independent of statement order.
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_wdata_q <= ram_wdata_d;
      wr_ack_q    <= wr_ack_d;
      wr_err_q    <= wr_err_d;
      ptr_q       <= ptr_d;
      disp_v1_q   <= disp_v1_d;
      disp_v2_q   <= disp_v2_d;
      d_valid_q   <= d_valid_d;
      d_out_q     <= d_out_d;
    end
  end

  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;
  assign wr_ack    = wr_ack_q;
  assign wr_err    = wr_err_q;
  assign d_valid   = d_valid_q;
  assign d_out     = d_out_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed vectors, hand sequences for
// reset/latency corners, then random traffic against a behavioural model.
module tb_vram_arbiter;

  logic        vga_clk = 1'b0;
  logic        clrn;
  logic        rdn;
  logic [9:0]  row_addr, col_addr;
  logic [11:0] d_out;
  logic        d_valid;
  logic [1:0]  wr_req;
  logic [14:0] wr_addr0, wr_addr1;
  logic [11:0] wr_data0, wr_data1;
  logic [1:0]  wr_ack;
  logic        wr_err;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [11:0] ram_wdata;
  logic [11:0] ram_rdata;

  always #5 vga_clk = ~vga_clk;

  vram_arbiter dut (
    .vga_clk   (vga_clk),
    .clrn      (clrn),
    .rdn       (rdn),
    .row_addr  (row_addr),
    .col_addr  (col_addr),
    .d_out     (d_out),
    .d_valid   (d_valid),
    .wr_req    (wr_req),
    .wr_addr0  (wr_addr0),
    .wr_addr1  (wr_addr1),
    .wr_data0  (wr_data0),
    .wr_data1  (wr_data1),
    .wr_ack    (wr_ack),
    .wr_err    (wr_err),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  // Frame-buffer RAM model: synchronous read, write on ram_we.
  function automatic logic [11:0] pat(input int i);
    return (i == 0) ? 12'hABC : (12'(i) ^ 12'h5A3);
  endfunction

  logic        mem_init = 1'b0;
  logic [11:0] mem [0:32767];

  always @(posedge vga_clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32768; i++) mem[i] <= pat(i);
    end else begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [43:0] act, input logic [43:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic tick();
    @(negedge vga_clk);
  endtask

  function automatic logic [43:0] obs_all();
    return {ram_we, ram_addr, ram_wdata, wr_ack, wr_err, d_valid, d_out};
  endfunction

  function automatic logic [43:0] obs_wr();
    return 44'({ram_we, ram_addr, ram_wdata, wr_ack, wr_err});
  endfunction

  function automatic logic [43:0] exp_wr(input logic we, input int addr, input int wdata,
                                         input int ack, input logic err);
    return 44'({we, 15'(addr), 12'(wdata), 2'(ack), err});
  endfunction

  typedef struct {
    logic        rdn;
    logic [9:0]  row, col;
    logic [1:0]  req;
    logic [14:0] a0, a1;
    logic [11:0] d0, d1;
    logic [14:0] e_addr;
    logic        e_we;
    logic [11:0] e_wdata;
    logic [1:0]  e_ack;
    logic        e_err;
  } vec_t;

  function automatic vec_t mk(input logic r, input int row, input int col, input int req,
                              input int a0, input int d0, input int a1, input int d1,
                              input int e_addr, input logic e_we, input int e_wdata,
                              input int e_ack, input logic e_err);
    vec_t v;
    v.rdn = r; v.row = 10'(row); v.col = 10'(col); v.req = 2'(req);
    v.a0 = 15'(a0); v.d0 = 12'(d0); v.a1 = 15'(a1); v.d1 = 12'(d1);
    v.e_addr = 15'(e_addr); v.e_we = e_we; v.e_wdata = 12'(e_wdata);
    v.e_ack = 2'(e_ack); v.e_err = e_err;
    return v;
  endfunction

  // Behavioural reference state for the random phase.
  typedef struct packed {
    logic        v;
    logic [11:0] d;
  } dexp_t;

  logic [11:0] shadow [0:32767];
  dexp_t       dq[$];
  logic [14:0] m_addr;
  logic        m_we;
  logic [11:0] m_wdata;
  logic [1:0]  m_ack;
  logic        m_err;
  logic        m_dv;
  logic [11:0] m_d;
  int          m_turn;

  // Outcome of the decision made from the inputs present at the coming edge.
  task automatic model_step();
    logic [1:0] elig;
    int         g;
    int         a;
    dexp_t      ne;
    ne    = '0;
    elig  = wr_req & ~m_ack;
    m_we  = 1'b0;
    m_ack = 2'b00;
    m_err = 1'b0;
    if (!rdn) begin
      a      = (int'(row_addr) / 4) * 160 + int'(col_addr) / 4;
      m_addr = 15'(a);
      ne.v   = 1'b1;
      ne.d   = shadow[a];
    end else if (elig != 2'b00) begin
      g        = (elig == 2'b11) ? m_turn : (elig[0] ? 0 : 1);
      m_turn   = 1 - g;
      m_ack[g] = 1'b1;
      a        = (g == 0) ? int'(wr_addr0) : int'(wr_addr1);
      if (a < 160 * 120) begin
        m_we      = 1'b1;
        m_addr    = 15'(a);
        m_wdata   = (g == 0) ? wr_data0 : wr_data1;
        shadow[a] = m_wdata;
      end else begin
        m_err = 1'b1;
      end
    end
    dq.push_back(ne);
    ne   = dq.pop_front();
    m_dv = ne.v;
    m_d  = ne.d;
  endtask

  task automatic do_reset();
    clrn = 1'b0;
    rdn = 1'b1; wr_req = 2'b00;
    tick();
    tick();
    clrn = 1'b1;
  endtask

  vec_t tbl[14];
  logic w_hold [2];

  initial begin
    clrn = 1'b0; rdn = 1'b0; row_addr = '0; col_addr = '0;
    wr_req = 2'b11; wr_addr0 = 15'd10; wr_addr1 = 15'd20;
    wr_data0 = 12'h0A1; wr_data1 = 12'h0B2;

    // Reset hold with a read and both writers pending.
    mem_init = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      mem_init = 1'b0;
      check("reset_hold", obs_all(), 44'd0);
    end

    // Pointer starts at writer 0; held requests alternate through the ack mask.
    clrn = 1'b1; rdn = 1'b1;
    tick(); check("rr_w0_a", obs_wr(), exp_wr(1, 10, 'h0A1, 1, 0));
    tick(); check("rr_w1_a", obs_wr(), exp_wr(1, 20, 'h0B2, 2, 0));
    tick(); check("rr_w0_b", obs_wr(), exp_wr(1, 10, 'h0A1, 1, 0));
    tick(); check("rr_w1_b", obs_wr(), exp_wr(1, 20, 'h0B2, 2, 0));
    wr_req = 2'b00;
    tick(); check("rr_idle", obs_wr(), exp_wr(0, 20, 'h0B2, 0, 0));

    // Display beats a pending writer; the writer goes next.
    rdn = 1'b0; row_addr = 10'd5; col_addr = 10'd13;
    wr_req = 2'b01; wr_addr0 = 15'd77; wr_data0 = 12'h0C3;
    tick(); check("disp_prio", obs_wr(), exp_wr(0, 163, 'h0B2, 0, 0));
    rdn = 1'b1;
    tick(); check("disp_then_w0", obs_wr(), exp_wr(1, 77, 'h0C3, 1, 0));
    wr_req = 2'b00;
    tick();

    // Directed vectors from a clean reset.
    do_reset();
    tbl[0]  = mk(0,   0,   0, 0,     0,     0,     0,     0,     0, 0,     0, 0, 0);
    tbl[1]  = mk(0,   5,  13, 0,     0,     0,     0,     0,   163, 0,     0, 0, 0);
    tbl[2]  = mk(1,   0,   0, 1,    10, 'h111,     0,     0,    10, 1, 'h111, 1, 0);
    tbl[3]  = mk(0, 479, 639, 0,     0,     0,     0,     0, 19199, 0, 'h111, 0, 0);
    tbl[4]  = mk(1,   0,   0, 2,     0,     0, 19200, 'h222, 19199, 0, 'h111, 2, 1);
    tbl[5]  = mk(1,   0,   0, 0,     0,     0,     0,     0, 19199, 0, 'h111, 0, 0);
    tbl[6]  = mk(1,   0,   0, 2,     0,     0, 19199, 'h333, 19199, 1, 'h333, 2, 0);
    tbl[7]  = mk(1,   0,   0, 3,     1, 'h444,     2, 'h555,     1, 1, 'h444, 1, 0);
    tbl[8]  = mk(1,   0,   0, 3,     1, 'h444,     2, 'h555,     2, 1, 'h555, 2, 0);
    tbl[9]  = mk(1,   0,   0, 3, 32767, 'h444,     2, 'h555,     2, 0, 'h555, 1, 1);
    tbl[10] = mk(0, 100, 200, 3,     3, 'h666,     4, 'h777,  4050, 0, 'h555, 0, 0);
    tbl[11] = mk(1,   0,   0, 3,     3, 'h666,     4, 'h777,     4, 1, 'h777, 2, 0);
    tbl[12] = mk(0, 478,   1, 0,     0,     0,     0,     0, 19040, 0, 'h777, 0, 0);
    tbl[13] = mk(0,   3,   3, 0,     0,     0,     0,     0,     0, 0, 'h777, 0, 0);
    for (int i = 0; i < 14; i++) begin
      rdn = tbl[i].rdn; row_addr = tbl[i].row; col_addr = tbl[i].col;
      wr_req = tbl[i].req;
      wr_addr0 = tbl[i].a0; wr_data0 = tbl[i].d0;
      wr_addr1 = tbl[i].a1; wr_data1 = tbl[i].d1;
      tick();
      check($sformatf("vec%0d", i), obs_wr(),
            44'({tbl[i].e_we, tbl[i].e_addr, tbl[i].e_wdata, tbl[i].e_ack, tbl[i].e_err}));
    end

    // Read latency: rdn=0 sample to d_valid is exactly three cycles.
    rdn = 1'b1; wr_req = 2'b00;
    tick(); tick();
    rdn = 1'b0; row_addr = '0; col_addr = '0;
    tick(); check("lat_c1", 44'({d_valid, d_out}), 44'({1'b0, 12'h000}));
    rdn = 1'b1;
    tick(); check("lat_c2", 44'({d_valid, d_out}), 44'({1'b0, 12'h000}));
    tick(); check("lat_c3", 44'({d_valid, d_out}), 44'({1'b1, 12'hABC}));
    tick(); check("lat_c4", 44'({d_valid, d_out}), 44'({1'b0, 12'h000}));

    // Reset on the decision cycle cancels the write; re-request succeeds.
    wr_req = 2'b01; wr_addr0 = 15'd50; wr_data0 = 12'h5A5; clrn = 1'b0;
    tick(); check("rst_mid", obs_all(), 44'd0);
    clrn = 1'b1;
    tick(); check("rst_rereq", obs_wr(), exp_wr(1, 50, 'h5A5, 1, 0));
    wr_req = 2'b00;
    tick();

    // Random traffic against the behavioural model.
    mem_init = 1'b1;
    clrn = 1'b0; rdn = 1'b1; wr_req = 2'b00;
    tick();
    mem_init = 1'b0;
    tick();
    clrn = 1'b1;
    for (int i = 0; i < 32768; i++) shadow[i] = pat(i);
    dq.delete();
    dq.push_back('0);
    dq.push_back('0);
    m_addr = '0; m_we = 1'b0; m_wdata = '0; m_ack = 2'b00; m_err = 1'b0;
    m_dv = 1'b0; m_d = '0; m_turn = 0;
    w_hold[0] = 1'b0; w_hold[1] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      check("rand", obs_all(), {m_we, m_addr, m_wdata, m_ack, m_err, m_dv, m_d});
      for (int w = 0; w < 2; w++) begin
        if (m_ack[w]) begin
          if ($urandom_range(0, 1) == 0) wr_req[w] = 1'b0;
          else w_hold[w] = 1'b1;
        end else if (w_hold[w]) begin
          wr_req[w] = 1'b0;
          w_hold[w] = 1'b0;
        end else if (!wr_req[w] && $urandom_range(0, 2) == 0) begin
          wr_req[w] = 1'b1;
          if (w == 0) begin
            wr_addr0 = ($urandom_range(0, 7) == 0) ? 15'($urandom_range(19200, 32767))
                                                  : 15'($urandom_range(0, 19199));
            wr_data0 = 12'($urandom_range(0, 4095));
          end else begin
            wr_addr1 = ($urandom_range(0, 7) == 0) ? 15'($urandom_range(19200, 32767))
                                                  : 15'($urandom_range(0, 19199));
            wr_data1 = 12'($urandom_range(0, 4095));
          end
        end
      end
      rdn      = ($urandom_range(0, 1) == 0);
      row_addr = 10'($urandom_range(0, 479));
      col_addr = 10'($urandom_range(0, 639));
      model_step();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
